qsys_sdram_cpu_mul_arbiter: RTL and testbench
=============================================

// Module: qsys_sdram_cpu_mul_arbiter
// PURPOSE
//   Shares one pipelined 32x32->32 multiplier cell between NUM_REQ requesters.
//   - Requesters: CPU custom-instruction ports, DMA address scalers.
//   - Arbitration: round-robin, one issue per cycle.
//   - Each operation's cell result is routed back to the requester that issued it, through a
//     per-requester result register with valid/ready backpressure.
//   - Sits between the requesters and the multiplier cell in the CPU subsystem.
// PARAMETERS
//   NUM_REQ      2  number of requesters (2..4)
//   MUL_LATENCY  1  cycles from operands presented to cell until A_mul_cell_result valid (1..4)
// PORTS
//   clk                input   1          system clock; all state on rising edge
//   reset_n            input   1          asynchronous active-low reset
//   req_valid          input   NUM_REQ    requester i has an operation pending
//   req_ready          output  NUM_REQ    requester i's operation accepted this cycle
//   req_src1           input   32*NUM_REQ operand 1, requester i at [32i+31:32i]
//   req_src2           input   32*NUM_REQ operand 2, same packing
//   rsp_valid          output  NUM_REQ    result for requester i held in rsp_result
//   rsp_ready          input   NUM_REQ    requester i consumes its result
//   rsp_result         output  32*NUM_REQ low 32 bits of product, same packing
//   A_mul_src1         output  32         operand 1 to multiplier cell
//   A_mul_src2         output  32         operand 2 to multiplier cell
//   A_mul_cell_result  input   32         cell result, MUL_LATENCY cycles after operands
//   mul_busy           output  1          any operation in flight in the cell
// BEHAVIOUR
//   Clock and reset
//   - One clock (clk); reset_n is asynchronous, active-low.
//   Reset
//   - req_ready=0, rsp_valid=0, rsp_result=0, A_mul_src1/2=0, mul_busy=0.
//   - All slots IDLE, tag pipe cleared, round-robin pointer=0.
//   Per-requester slot FSM
//   - IDLE -> BUSY on issue.
//   - BUSY -> DONE when its tag exits the pipe.
//   - DONE -> IDLE on rsp_valid&rsp_ready.
//   - At most one outstanding op per requester.
//   Arbitration (combinational)
//   - Eligible set = req_valid & (slot==IDLE).
//   - Grant the first eligible index at or after the pointer, wrapping mod NUM_REQ.
//   - req_ready = one-hot grant; all zero if the eligible set is empty.
//   - Issue = req_valid[i]&req_ready[i]. After an issue to i, the pointer becomes (i+1) mod NUM_REQ;
//     with no issue the pointer holds.
//   Issue datapath
//   - In the issue cycle T, A_mul_src1/2 = granted operands (combinational mux);
//     otherwise A_mul_src1/2 = 0.
//   - Tag pipe: MUL_LATENCY stages of {valid, id}. Stage 0 loads {issue, grant id} at the end of cycle T.
//   Completion
//   - The tag exits in cycle T+MUL_LATENCY; A_mul_cell_result is captured into rsp_result[id] at the end of that cycle.
//   - rsp_valid[id]=1 from cycle T+MUL_LATENCY+1.
//   - Minimum issue-to-response latency is MUL_LATENCY+1 cycles.
//   - rsp_result is stable while rsp_valid=1 and rsp_ready=0.
//   Re-issue
//   - A slot is IDLE in the cycle after rsp accept. Earliest re-issue is then, so same-cycle accept+issue for one requester never occurs.
//   Throughput
//   - One issue per cycle across requesters; back-to-back issues from different requesters are allowed.
//   Arithmetic
//   - result = (src1*src2) mod 2^32; the low word is identical for signed and unsigned operands.
//   mul_busy
//   - OR of tag pipe valid bits.
//   Boundaries
//   - Requester blocked in BUSY/DONE: its req_valid is ignored and other requesters are still granted.
//   - Simultaneous completion for i and issue for j is legal.
//   - Reset asserted mid-operation discards in-flight tags and held results; no rsp_valid is produced after release.
// TESTING
//   1. Single op: req0 3*5, rsp_ready=1, MUL_LATENCY=1 -> req_ready[0] in cycle T, rsp_valid[0] in T+2 with result 15, high 1 cycle.
//   2. Wrap: 0xFFFFFFFF*2 -> 0xFFFFFFFE; 0x00010000*0x00010000 -> 0x00000000.
//   3. Fairness: req_valid=2'b11 held, rsp_ready=11 -> grants alternate 0,1,0,1...
//      Requester 0 is not re-granted before its rsp accept; all results correct.
//   4. Backpressure: rsp_ready[0]=0 for 10 cycles -> rsp_result[0] stable, req_ready[0]=0.
//      Requester 1 keeps issuing; after accept, req0 is granted the next cycle.
//   5. Reset mid-flight: reset_n low for 1 cycle right after issue (T+1) -> all outputs 0.
//      No rsp_valid after release; the first grant goes to requester 0.
//   6. Randomized valid/ready with MUL_LATENCY=3 and NUM_REQ=4 vs a reference model.
//      All products match; each requester has at most one op outstanding; mul_busy matches in-flight count>0.

Source files
------------

// File: rtl/qsys_sdram_cpu_mul_arbiter.sv
// rtl/qsys_sdram_cpu_mul_arbiter.sv - round-robin sharing of one pipelined 32x32 multiplier cell
module qsys_sdram_cpu_mul_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int MUL_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_src1,
    input  logic [32*NUM_REQ-1:0]   req_src2,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [32*NUM_REQ-1:0]   rsp_result,
    output logic [31:0]             A_mul_src1,
    output logic [31:0]             A_mul_src2,
    input  logic [31:0]             A_mul_cell_result,
    output logic                    mul_busy
);

    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             slot [NUM_REQ];
    logic [IDW-1:0]         ptr;
    logic [MUL_LATENCY-1:0] tag_valid;
    logic [IDW-1:0]         tag_id [MUL_LATENCY];

    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     grant;
    logic [IDW-1:0]         grant_id;
    logic                   issue;
    int                     idx_c;

    logic                   exit_valid;
    logic [IDW-1:0]         exit_id;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i]  = req_valid[i] && (slot[i] == S_IDLE);
            rsp_valid[i] = (slot[i] == S_DONE);
        end
    end

    // Search starts at the pointer and wraps, so the last-served requester goes to the back.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        issue    = 1'b0;
        idx_c    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_c = int'(ptr) + k;
            if (idx_c >= NUM_REQ) begin
                idx_c = idx_c - NUM_REQ;
            end
            if (!issue && eligible[idx_c]) begin
                issue        = 1'b1;
                grant[idx_c] = 1'b1;
                grant_id     = IDW'(idx_c);
            end
        end
    end

    assign req_ready = grant;

    always_comb begin
        A_mul_src1 = '0;
        A_mul_src2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                A_mul_src1 = req_src1[32*i +: 32];
                A_mul_src2 = req_src2[32*i +: 32];
            end
        end
    end

    assign exit_valid = tag_valid[MUL_LATENCY-1];
    assign exit_id    = tag_id[MUL_LATENCY-1];
    assign mul_busy   = |tag_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // Tag pipe mirrors the cell latency so each result can be steered to its issuer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid <= '0;
            for (int s = 0; s < MUL_LATENCY; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_valid[0] <= issue;
            tag_id[0]    <= grant_id;
            for (int s = 1; s < MUL_LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_result <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot[i] <= S_IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case (slot[i])
                    S_IDLE: begin
                        if (grant[i]) begin
                            slot[i] <= S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        if (exit_valid && (exit_id == IDW'(i))) begin
                            slot[i]                <= S_DONE;
                            rsp_result[32*i +: 32] <= A_mul_cell_result;
                        end
                    end
                    S_DONE: begin
                        if (rsp_ready[i]) begin
                            slot[i] <= S_IDLE;
                        end
                    end
                    default: begin
                        slot[i] <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qsys_sdram_cpu_mul_arbiter.sv
// tb/tb_qsys_sdram_cpu_mul_arbiter.sv - directed and randomized bench for the multiplier arbiter
module tb_qsys_sdram_cpu_mul_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Instance A: two requesters, single-cycle cell
    logic [1:0]  a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [63:0] a_src1, a_src2, a_rsp_result;
    logic [31:0] a_mul_src1, a_mul_src2, a_cell;
    logic        a_busy;

    // Instance B: four requesters, three-cycle cell
    logic [3:0]   b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [127:0] b_src1, b_src2, b_rsp_result;
    logic [31:0]  b_mul_src1, b_mul_src2, b_cell;
    logic [31:0]  b_pipe [3];
    logic         b_busy;

    qsys_sdram_cpu_mul_arbiter #(.NUM_REQ(2), .MUL_LATENCY(1)) dut_a (
        .clk(clk), .reset_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_src1(a_src1), .req_src2(a_src2),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_result(a_rsp_result),
        .A_mul_src1(a_mul_src1), .A_mul_src2(a_mul_src2),
        .A_mul_cell_result(a_cell), .mul_busy(a_busy)
    );

    qsys_sdram_cpu_mul_arbiter #(.NUM_REQ(4), .MUL_LATENCY(3)) dut_b (
        .clk(clk), .reset_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_src1(b_src1), .req_src2(b_src2),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_result(b_rsp_result),
        .A_mul_src1(b_mul_src1), .A_mul_src2(b_mul_src2),
        .A_mul_cell_result(b_cell), .mul_busy(b_busy)
    );

    // Multiplier cell models
    always @(posedge clk) begin
        a_cell    <= a_mul_src1 * a_mul_src2;
        b_pipe[0] <= b_mul_src1 * b_mul_src2;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_cell = b_pipe[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic a_single(input int r, input logic [31:0] s1, input logic [31:0] s2,
                            input logic [31:0] exp, input string tag);
        logic got;
        @(posedge clk); #1;
        a_src1[32*r +: 32] = s1;
        a_src2[32*r +: 32] = s2;
        a_req_valid        = 2'b00;
        a_req_valid[r]     = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (a_req_ready[r]) got = 1'b1;
        end
        chk({tag, "_grant"}, got, 1'b1);
        @(posedge clk); #1;
        a_req_valid = 2'b00;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (a_rsp_valid[r]) got = 1'b1;
        end
        chk({tag, "_rsp"}, got, 1'b1);
        chk({tag, "_res"}, a_rsp_result[32*r +: 32], exp);
    endtask

    logic [31:0] exp_res [2];
    logic [31:0] held;
    int          last_g, n_grants, n1;
    logic        got;

    // Reference model state for instance B
    int          m_st  [4];
    int          m_cnt [4];
    logic [31:0] m_val [4];
    logic [31:0] m_res [4];
    int          m_ptr, exp_g, n_acc, busy_cnt;
    logic [3:0]  exp_ready;
    logic [31:0] exp_s1, exp_s2;
    logic [63:0] prod;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a_req_valid = '0; a_rsp_ready = '0; a_src1 = '0; a_src2 = '0;
        b_req_valid = '0; b_rsp_ready = '0; b_src1 = '0; b_src2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", a_req_ready, 0);
        chk("rst_a_rspv", a_rsp_valid, 0);
        chk("rst_a_res", a_rsp_result, 0);
        chk("rst_a_src", {a_mul_src1, a_mul_src2}, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_b_rspv", b_rsp_valid, 0);
        chk("rst_b_busy", b_busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single op 3*5
        @(posedge clk); #1;
        a_src1[31:0] = 32'd3; a_src2[31:0] = 32'd5;
        a_req_valid = 2'b01; a_rsp_ready = 2'b11;
        @(negedge clk);
        chk("t1_ready", a_req_ready, 2'b01);
        chk("t1_src1", a_mul_src1, 3);
        chk("t1_src2", a_mul_src2, 5);
        @(posedge clk); #1;
        a_req_valid = 2'b00;
        @(negedge clk);
        chk("t1_busy", a_busy, 1);
        chk("t1_rsp_early", a_rsp_valid, 0);
        @(negedge clk);
        chk("t1_rspv", a_rsp_valid, 2'b01);
        chk("t1_res", a_rsp_result[31:0], 15);
        chk("t1_idle", a_busy, 0);
        @(negedge clk);
        chk("t1_rsp_pulse", a_rsp_valid, 0);

        // Wrap-around products
        a_single(0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "t2_wrap");
        a_single(1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "t2_zero");

        // Fairness: both requesters always valid
        @(posedge clk); #1;
        a_req_valid = 2'b11; a_rsp_ready = 2'b11;
        a_src1 = {$urandom, $urandom}; a_src2 = {$urandom, $urandom};
        last_g = 1; n_grants = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (a_req_ready != 2'b00) begin
                chk("t3_alt", a_req_ready, (last_g == 0) ? 2'b10 : 2'b01);
                last_g = a_req_ready[1] ? 1 : 0;
                prod = 64'(a_src1[32*last_g +: 32]) * 64'(a_src2[32*last_g +: 32]);
                exp_res[last_g] = prod[31:0];
                n_grants++;
            end
            for (int r = 0; r < 2; r++) begin
                if (a_rsp_valid[r]) chk("t3_res", a_rsp_result[32*r +: 32], exp_res[r]);
            end
            @(posedge clk); #1;
            a_src1 = {$urandom, $urandom}; a_src2 = {$urandom, $urandom};
        end
        a_req_valid = 2'b00;
        chk("t3_count", n_grants >= 8, 1'b1);
        repeat (4) @(posedge clk);

        // Backpressure on requester 0
        #1;
        a_rsp_ready = 2'b10; a_req_valid = 2'b11;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (a_req_ready[r]) begin
                    prod = 64'(a_src1[32*r +: 32]) * 64'(a_src2[32*r +: 32]);
                    exp_res[r] = prod[31:0];
                end
            end
            if (a_rsp_valid[0]) got = 1'b1;
            else begin
                @(posedge clk); #1;
                a_src1 = {$urandom, $urandom}; a_src2 = {$urandom, $urandom};
            end
        end
        chk("t4_rsp0", got, 1'b1);
        chk("t4_res0", a_rsp_result[31:0], exp_res[0]);
        held = a_rsp_result[31:0];
        n1 = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            a_src1 = {$urandom, $urandom}; a_src2 = {$urandom, $urandom};
            @(negedge clk);
            chk("t4_stable", a_rsp_result[31:0], held);
            chk("t4_rspv0", a_rsp_valid[0], 1'b1);
            chk("t4_block0", a_req_ready[0], 1'b0);
            if (a_rsp_valid[1]) chk("t4_res1", a_rsp_result[63:32], exp_res[1]);
            if (a_req_ready[1]) begin
                prod = 64'(a_src1[63:32]) * 64'(a_src2[63:32]);
                exp_res[1] = prod[31:0];
                n1++;
            end
        end
        chk("t4_r1_issues", n1 >= 3, 1'b1);
        @(posedge clk); #1;
        a_rsp_ready = 2'b11; a_req_valid = 2'b01;
        @(negedge clk);
        chk("t4_accept", a_rsp_valid[0], 1'b1);
        @(posedge clk); #1;
        a_src1[31:0] = 32'd7; a_src2[31:0] = 32'd6;
        @(negedge clk);
        chk("t4_regrant", a_req_ready, 2'b01);

        // Reset right after an issue
        @(posedge clk); #1;
        a_req_valid = 2'b00; rst_n = 1'b0;
        @(negedge clk);
        chk("t5_ready", a_req_ready, 0);
        chk("t5_rspv", a_rsp_valid, 0);
        chk("t5_res", a_rsp_result, 0);
        chk("t5_src", {a_mul_src1, a_mul_src2}, 0);
        chk("t5_busy", a_busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_no_rsp", a_rsp_valid, 0);
        end
        @(posedge clk); #1;
        a_req_valid = 2'b11;
        @(negedge clk);
        chk("t5_first", a_req_ready, 2'b01);
        @(posedge clk); #1;
        a_req_valid = 2'b00;

        // Randomized run on instance B against the reference model
        for (int r = 0; r < 4; r++) begin
            m_st[r] = 0; m_cnt[r] = 0; m_val[r] = '0; m_res[r] = '0;
        end
        m_ptr = 0; n_acc = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            b_req_valid = 4'($urandom);
            b_rsp_ready = 4'($urandom);
            b_src1 = {$urandom, $urandom, $urandom, $urandom};
            b_src2 = {$urandom, $urandom, $urandom, $urandom};
            if (c % 7 == 0) b_src1[31:0] = 32'hFFFF_FFFF;
            @(negedge clk);
            exp_g = -1;
            for (int k = 0; k < 4; k++) begin
                if (exp_g < 0 && b_req_valid[(m_ptr + k) % 4] && m_st[(m_ptr + k) % 4] == 0)
                    exp_g = (m_ptr + k) % 4;
            end
            exp_ready = '0; exp_s1 = '0; exp_s2 = '0;
            if (exp_g >= 0) begin
                exp_ready[exp_g] = 1'b1;
                exp_s1 = b_src1[32*exp_g +: 32];
                exp_s2 = b_src2[32*exp_g +: 32];
            end
            busy_cnt = 0;
            for (int r = 0; r < 4; r++) if (m_st[r] == 1) busy_cnt++;
            chk("t6_ready", b_req_ready, exp_ready);
            chk("t6_src1", b_mul_src1, exp_s1);
            chk("t6_src2", b_mul_src2, exp_s2);
            chk("t6_busy", b_busy, busy_cnt > 0);
            for (int r = 0; r < 4; r++) begin
                chk("t6_rspv", b_rsp_valid[r], m_st[r] == 2);
                chk("t6_res", b_rsp_result[32*r +: 32], m_res[r]);
            end
            for (int r = 0; r < 4; r++) begin
                if (m_st[r] == 1) begin
                    if (m_cnt[r] == 1) begin
                        m_st[r] = 2; m_res[r] = m_val[r];
                    end else m_cnt[r]--;
                end else if (m_st[r] == 2 && b_rsp_ready[r]) begin
                    m_st[r] = 0; n_acc++;
                end
            end
            if (exp_g >= 0) begin
                prod = 64'(exp_s1) * 64'(exp_s2);
                m_st[exp_g] = 1; m_cnt[exp_g] = 3; m_val[exp_g] = prod[31:0];
                m_ptr = (exp_g + 1) % 4;
            end
        end
        chk("t6_accepts", n_acc > 20, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
